data_plane_tx: RTL and testbench

DATA_PLANE_TX -- requirements
Module: data_plane_tx

---
 rtl/data_plane_tx.sv | 142 ++++++++++++++
 tb/tb_data_plane_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_plane_tx.sv
// data_plane_tx: GPP transmit stack (LIFO) feeding the 32-bit data plane.
// A transfer sends PKT_LEN packets {dest, word}, top of stack first, once the
// control plane grants the bus, then one idle packet with a completion pulse.
// Optional feature: define DATA_TX_SELF_CHECK_EN to reject requests addressed
// to this node's own id (tx_error pulses, no transfer).
module data_plane_tx #(
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                node_id,
    input  logic                       gpp_wr_en,
    input  logic [15:0]                gpp_wr_data,
    input  logic [15:0]                dest_id,
    input  logic                       tx_request,
    input  logic                       tx_grant,
    output logic [31:0]                data_tx_packet,
    output logic                       tx_busy,
    output logic                       data_tx_complete_flag,
    output logic                       tx_error,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       buf_full
);

    localparam int              SPW       = $clog2(DEPTH + 1);
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     IDLE_PKT  = 32'hFFFF_0000;
    localparam logic [SPW-1:0]  DEPTH_C   = SPW'(DEPTH);
    localparam logic [SPW-1:0]  PKT_LEN_C = SPW'(PKT_LEN);
    localparam logic [SPW-1:0]  SP_ONE    = SPW'(1);
    localparam logic [2:0]      CNT_LAST  = 3'(PKT_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GRANT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [2:0]     r_cnt;
    logic [15:0]    r_dest;
    logic [31:0]    r_pkt;

    logic           w_full;
    logic           w_req_ok;
    logic           w_self;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [SPW-1:0] w_sp_m1;
    logic [AW-1:0]  w_rd_idx;
    logic [AW-1:0]  w_wr_idx;

    assign w_full   = (r_sp == DEPTH_C);
    assign w_req_ok = tx_request && (r_sp >= PKT_LEN_C);

`ifdef DATA_TX_SELF_CHECK_EN
    logic r_err;

    assign w_self = (dest_id == node_id);

    // One-cycle error pulse when an otherwise valid request targets ourselves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= (r_state == ST_IDLE) && w_req_ok && w_self;
    end

    assign tx_error = r_err;
`else
    logic w_unused_node_id;

    assign w_self           = 1'b0;
    assign w_unused_node_id = ^node_id;
    assign tx_error         = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && w_req_ok && !w_self;
    assign w_push   = ((r_state == ST_IDLE) || (r_state == ST_WAIT_GRANT)) && gpp_wr_en && !w_full;
    assign w_pop    = ((r_state == ST_WAIT_GRANT) && tx_grant) ||
                      ((r_state == ST_SEND) && (r_cnt < CNT_LAST));
    assign w_sp_m1  = r_sp - SP_ONE;
    assign w_rd_idx = w_sp_m1[AW-1:0];
    // A push landing on the grant edge replaces the word being popped, so the
    // stack stays contiguous while sp is left unchanged.
    assign w_wr_idx = w_pop ? w_sp_m1[AW-1:0] : r_sp[AW-1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept) w_next = ST_WAIT_GRANT;
            ST_WAIT_GRANT: if (tx_grant) w_next = ST_SEND;
            ST_SEND:       if (r_cnt >= CNT_LAST) w_next = ST_DONE;
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Stack storage; contents survive reset, only sp is cleared
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= gpp_wr_data;
    end

    // Stack pointer, packet counter, latched destination and output packet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp   <= '0;
            r_cnt  <= '0;
            r_dest <= '0;
            r_pkt  <= IDLE_PKT;
        end else begin
            if (w_push && !w_pop)      r_sp <= r_sp + SP_ONE;
            else if (w_pop && !w_push) r_sp <= w_sp_m1;

            if (w_pop)                  r_cnt <= (r_state == ST_WAIT_GRANT) ? 3'd1 : r_cnt + 3'd1;
            else if (r_state != ST_SEND) r_cnt <= '0;

            if (w_accept) r_dest <= dest_id;

            if (w_pop)                   r_pkt <= {r_dest, r_mem[w_rd_idx]};
            else if (r_state == ST_SEND) r_pkt <= IDLE_PKT;
        end
    end

    assign data_tx_packet        = r_pkt;
    assign tx_busy               = (r_state != ST_IDLE);
    assign data_tx_complete_flag = (r_state == ST_DONE);
    assign buf_count             = r_sp;
    assign buf_full              = w_full;

endmodule

// File: tb/tb_data_plane_tx.sv
// Testbench for data_plane_tx: a model stack produces the expected packets at
// request time into a scoreboard queue; a negedge monitor pops and compares
// every non-idle packet the DUT emits.
module tb_data_plane_tx;

    localparam int          DEPTH    = 8;
    localparam int          PKT_LEN  = 5;
    localparam int          SPW      = $clog2(DEPTH + 1);
    localparam logic [31:0] IDLE_PKT = 32'hFFFF_0000;

    logic           clk = 1'b0;
    logic           rst;
    logic [15:0]    node_id;
    logic           gpp_wr_en;
    logic [15:0]    gpp_wr_data;
    logic [15:0]    dest_id;
    logic           tx_request;
    logic           tx_grant;
    logic [31:0]    data_tx_packet;
    logic           tx_busy;
    logic           data_tx_complete_flag;
    logic           tx_error;
    logic [SPW-1:0] buf_count;
    logic           buf_full;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] sb [$];
    logic [15:0] mstk [$];

    data_plane_tx #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .node_id               (node_id),
        .gpp_wr_en             (gpp_wr_en),
        .gpp_wr_data           (gpp_wr_data),
        .dest_id               (dest_id),
        .tx_request            (tx_request),
        .tx_grant              (tx_grant),
        .data_tx_packet        (data_tx_packet),
        .tx_busy               (tx_busy),
        .data_tx_complete_flag (data_tx_complete_flag),
        .tx_error              (tx_error),
        .buf_count             (buf_count),
        .buf_full              (buf_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && data_tx_packet !== IDLE_PKT) begin
            if (sb.size() == 0) check_eq("pkt_unexpected", data_tx_packet, IDLE_PKT);
            else                check_eq("pkt", data_tx_packet, sb.pop_front());
        end
    end

    // All stimulus tasks start and end on a falling edge
    task automatic push_word(input logic [15:0] d);
        gpp_wr_en   = 1'b1;
        gpp_wr_data = d;
        @(negedge clk);
        gpp_wr_en   = 1'b0;
        if (mstk.size() < DEPTH) mstk.push_back(d);
    endtask

    task automatic request(input logic [15:0] d);
        logic ok;
        logic self_rej;
        ok       = (mstk.size() >= PKT_LEN);
        self_rej = 1'b0;
`ifdef DATA_TX_SELF_CHECK_EN
        self_rej = ok && (d == node_id);
`endif
        dest_id    = d;
        tx_request = 1'b1;
        @(negedge clk);
        tx_request = 1'b0;
        if (ok && !self_rej)
            for (int i = 0; i < PKT_LEN; i++) sb.push_back({d, mstk.pop_back()});
        check_eq("req_err", tx_error, self_rej);
        check_eq("req_busy", tx_busy, ok && !self_rej);
    endtask

    // Called in WAIT_GRANT with tx_grant to be sampled on the next rising edge
    task automatic check_transfer(input int drop_at);
        check_eq("wait_busy", tx_busy, 1);
        check_eq("wait_pkt", data_tx_packet, IDLE_PKT);
        for (int i = 0; i < PKT_LEN; i++) begin
            @(negedge clk);
            check_eq("send_valid", data_tx_packet != IDLE_PKT, 1);
            check_eq("send_busy", tx_busy, 1);
            check_eq("send_flag", data_tx_complete_flag, 0);
            if (i == drop_at) tx_grant = 1'b0;
        end
        @(negedge clk);
        check_eq("done_pkt", data_tx_packet, IDLE_PKT);
        check_eq("done_flag", data_tx_complete_flag, 1);
        check_eq("done_busy", tx_busy, 1);
        @(negedge clk);
        check_eq("idle_flag", data_tx_complete_flag, 0);
        check_eq("idle_busy", tx_busy, 0);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        tx_grant = 1'b0;
        rst      = 1'b0;
        #3;
        rst      = 1'b1;
        mstk.delete();
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        node_id     = 16'h0001;
        gpp_wr_en   = 1'b0;
        gpp_wr_data = '0;
        dest_id     = '0;
        tx_request  = 1'b0;
        tx_grant    = 1'b0;

        // Reset state
        #7;
        check_eq("rst_pkt", data_tx_packet, IDLE_PKT);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_count", buf_count, 0);
        check_eq("rst_full", buf_full, 0);
        check_eq("rst_flag", data_tx_complete_flag, 0);
        check_eq("rst_err", tx_error, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic transfer, grant already high
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        check_eq("basic_count", buf_count, 5);
        tx_grant = 1'b1;
        request(16'h0003);
        check_transfer(-1);
        check_eq("basic_count_after", buf_count, 0);
        tx_grant = 1'b0;

        // Too few words: request ignored
        for (int i = 0; i < 3; i++) push_word(16'h00A0 + 16'(i));
        request(16'h0003);
        @(negedge clk);
        check_eq("short_busy", tx_busy, 0);
        check_eq("short_count", buf_count, 3);
        check_eq("short_err", tx_error, 0);

        // Overfill: ninth word dropped, surplus stays behind
        do_reset();
        for (int i = 1; i <= 9; i++) push_word(16'(i));
        check_eq("full_count", buf_count, DEPTH);
        check_eq("full_flag", buf_full, 1);
        tx_grant = 1'b1;
        request(16'h0007);
        check_transfer(-1);
        check_eq("full_left", buf_count, 3);
        check_eq("full_flag_after", buf_full, 0);
        tx_grant = 1'b0;

        // Late grant, then grant dropped mid-transfer
        do_reset();
        for (int i = 0; i < 5; i++) push_word(16'h0010 + 16'(i));
        request(16'h000A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_pkt", data_tx_packet, IDLE_PKT);
            check_eq("hold_busy", tx_busy, 1);
        end
        tx_grant = 1'b1;
        check_transfer(1);

        // Reset during the third SEND cycle
        do_reset();
        for (int i = 0; i < 5; i++) push_word(16'h0020 + 16'(i));
        tx_grant = 1'b1;
        request(16'h0004);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("abort_pkt", data_tx_packet, IDLE_PKT);
        check_eq("abort_count", buf_count, 0);
        check_eq("abort_busy", tx_busy, 0);
        check_eq("abort_sb_left", sb.size(), 2);
        sb.delete();
        mstk.delete();
        tx_grant = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_idle", tx_busy, 0);
        check_eq("abort_count2", buf_count, 0);

        // Request addressed to this node
        node_id = 16'h0002;
        for (int i = 0; i < 5; i++) push_word(16'h0030 + 16'(i));
        tx_grant = 1'b1;
        request(16'h0002);
`ifdef DATA_TX_SELF_CHECK_EN
        @(negedge clk);
        check_eq("self_err_clear", tx_error, 0);
        check_eq("self_busy", tx_busy, 0);
        check_eq("self_count", buf_count, 5);
        for (int i = 0; i < 8; i++) @(negedge clk);
`else
        check_transfer(-1);
        check_eq("self_count", buf_count, 0);
`endif
        tx_grant = 1'b0;
        check_eq("end_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
